// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux
// Brief    : Registered N-to-1 valid/ready stream mux with round-robin or
//            fixed-priority arbitration and optional burst lock.
// Revision : 1.0
// ============================================================================
module rr_stream_mux #(
    parameter int  IW      = 8,
    parameter int  NUM_CH  = 4,
    parameter int  RR_MODE = 1,
    parameter int  LOCK_EN = 1,
    localparam int CW      = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [NUM_CH*IW-1:0] i_Data,
    input  logic [NUM_CH-1:0]    i_Valid,
    input  logic [NUM_CH-1:0]    i_Last,
    output logic [NUM_CH-1:0]    o_In_Ready,
    output logic [IW-1:0]        o_Data,
    output logic                 o_Valid,
    output logic                 o_Last,
    output logic [CW-1:0]        o_Channel,
    input  logic                 i_Ready
);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_LOCKED = 1'b1;

    logic [0:0]        r_state;
    logic [CW-1:0]     r_lock_ch;
    logic [CW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_data;
    logic              r_valid;
    logic              r_last;
    logic [CW-1:0]     r_channel;

    logic              w_load;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_grant;
    logic [CW-1:0]     w_sel;
    logic              w_found;
    logic [CW-1:0]     w_start;
    logic [IW-1:0]     w_din;
    logic              w_last_in;
    logic              w_xfer;
    logic              w_complete;
    logic [CW-1:0]     w_ptr_next;
    int                w_idx;

    assign w_load  = !r_valid || i_Ready;
    assign w_start = (RR_MODE != 0) ? r_rr_ptr : '0;

    // While locked, only the owning channel may compete, even if it is idle.
    always_comb begin
        if (r_state == c_S_LOCKED)
            w_elig = i_Valid & (NUM_CH'(1) << r_lock_ch);
        else
            w_elig = i_Valid;
    end

    // Search upward from w_start with an exact wrap at NUM_CH.
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            w_idx = int'(w_start) + off;
            if (w_idx >= NUM_CH)
                w_idx = w_idx - NUM_CH;
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && (k == w_idx) && w_elig[k]) begin
                    w_found    = 1'b1;
                    w_grant[k] = 1'b1;
                    w_sel      = CW'(k);
                end
            end
        end
    end

    always_comb begin
        w_din     = '0;
        w_last_in = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant[k]) begin
                w_din     = i_Data[k*IW +: IW];
                w_last_in = i_Last[k];
            end
        end
    end

    assign o_In_Ready = (i_Reset || !w_load) ? '0 : w_grant;
    assign w_xfer     = |o_In_Ready;
    assign w_complete = w_xfer && ((LOCK_EN == 0) || w_last_in);
    assign w_ptr_next = (w_sel == CW'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= c_S_IDLE;
            r_lock_ch <= '0;
            r_rr_ptr  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_channel <= '0;
        end else begin
            if (w_xfer) begin
                r_data    <= w_din;
                r_last    <= w_last_in;
                r_channel <= w_sel;
                r_valid   <= 1'b1;
            end else if (i_Ready) begin
                r_valid   <= 1'b0;
            end

            if (w_xfer) begin
                if ((r_state == c_S_IDLE) && (LOCK_EN != 0) && !w_last_in) begin
                    r_state   <= c_S_LOCKED;
                    r_lock_ch <= w_sel;
                end else if (w_complete) begin
                    r_state   <= c_S_IDLE;
                end
                if (w_complete && (RR_MODE != 0))
                    r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign o_Data    = r_data;
    assign o_Valid   = r_valid;
    assign o_Last    = r_last;
    assign o_Channel = r_channel;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_mux
// Brief    : Directed bench for rr_stream_mux (4-ch RR+lock, 4-ch fixed, 3-ch RR).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 4 channels, round-robin, burst lock
    logic [31:0] a_data  = '0;
    logic [3:0]  a_valid = '0;
    logic [3:0]  a_last  = '0;
    logic [3:0]  a_in_ready;
    logic [7:0]  a_odata;
    logic        a_ovalid;
    logic        a_olast;
    logic [1:0]  a_ch;
    logic        a_ready = 1'b1;

    // Instance B: 4 channels, fixed priority
    logic [31:0] b_data  = '0;
    logic [3:0]  b_valid = '0;
    logic [3:0]  b_last  = '0;
    logic [3:0]  b_in_ready;
    logic [7:0]  b_odata;
    logic        b_ovalid;
    logic        b_olast;
    logic [1:0]  b_ch;
    logic        b_ready = 1'b1;

    // Instance C: 3 channels, round-robin
    logic [23:0] c_data  = '0;
    logic [2:0]  c_valid = '0;
    logic [2:0]  c_last  = '0;
    logic [2:0]  c_in_ready;
    logic [7:0]  c_odata;
    logic        c_ovalid;
    logic        c_olast;
    logic [1:0]  c_ch;
    logic        c_ready = 1'b1;

    rr_stream_mux #(.IW(8), .NUM_CH(4), .RR_MODE(1), .LOCK_EN(1)) u_a (
        .i_Clk(clk), .i_Reset(rst), .i_Data(a_data), .i_Valid(a_valid),
        .i_Last(a_last), .o_In_Ready(a_in_ready), .o_Data(a_odata),
        .o_Valid(a_ovalid), .o_Last(a_olast), .o_Channel(a_ch), .i_Ready(a_ready)
    );

    rr_stream_mux #(.IW(8), .NUM_CH(4), .RR_MODE(0), .LOCK_EN(1)) u_b (
        .i_Clk(clk), .i_Reset(rst), .i_Data(b_data), .i_Valid(b_valid),
        .i_Last(b_last), .o_In_Ready(b_in_ready), .o_Data(b_odata),
        .o_Valid(b_ovalid), .o_Last(b_olast), .o_Channel(b_ch), .i_Ready(b_ready)
    );

    rr_stream_mux #(.IW(8), .NUM_CH(3), .RR_MODE(1), .LOCK_EN(1)) u_c (
        .i_Clk(clk), .i_Reset(rst), .i_Data(c_data), .i_Valid(c_valid),
        .i_Last(c_last), .o_In_Ready(c_in_ready), .o_Data(c_odata),
        .o_Valid(c_ovalid), .o_Last(c_olast), .o_Channel(c_ch), .i_Ready(c_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with all A channels requesting: nothing may be accepted.
        a_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_last  = 4'hF;
        a_valid = 4'hF;
        tick();
        tick();
        check("rst_valid",    32'(a_ovalid),   32'h0);
        check("rst_data",     32'(a_odata),    32'h0);
        check("rst_in_ready", 32'(a_in_ready), 32'h0);

        // Round-robin rotation A0,A1,A2,A3,A0
        rst = 1'b0;
        #1;
        check("rr_grant0", 32'(a_in_ready), 32'h1);
        tick(); check("rr_beat0", 32'(a_odata), 32'hA0);
        tick(); check("rr_beat1", 32'(a_odata), 32'hA1);
        tick(); check("rr_beat2", 32'(a_odata), 32'hA2);
        tick(); check("rr_beat3", 32'(a_odata), 32'hA3);
        tick(); check("rr_beat4", 32'(a_odata), 32'hA0);
        check("rr_ch4", 32'(a_ch), 32'h0);

        // Backpressure for 3 cycles
        a_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(a_in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_data",     32'(a_odata),    32'hA0);
            check("bp_valid",    32'(a_ovalid),   32'h1);
            check("bp_in_ready", 32'(a_in_ready), 32'h0);
        end
        a_ready = 1'b1;
        tick();
        check("bp_release", 32'(a_odata), 32'hA1);

        // Burst lock on ch2 (rr_ptr now 2), ch0/ch1 compete throughout
        a_data  = {8'hA3, 8'hC0, 8'hA1, 8'hA0};
        a_valid = 4'b0111;
        a_last  = 4'b0011;
        tick();
        check("lk_ch_b0",   32'(a_ch),    32'h2);
        check("lk_data_b0", 32'(a_odata), 32'hC0);
        check("lk_last_b0", 32'(a_olast), 32'h0);
        a_valid = 4'b0011;
        #1;
        check("lk_gap_in_ready", 32'(a_in_ready), 32'h0);
        tick();
        check("lk_gap_drain", 32'(a_ovalid), 32'h0);
        a_data  = {8'hA3, 8'hC1, 8'hA1, 8'hA0};
        a_valid = 4'b0111;
        #1;
        check("lk_only_ch2", 32'(a_in_ready), 32'h4);
        tick();
        check("lk_ch_b1",   32'(a_ch),    32'h2);
        check("lk_data_b1", 32'(a_odata), 32'hC1);
        a_data = {8'hA3, 8'hC2, 8'hA1, 8'hA0};
        a_last = 4'b0111;
        tick();
        check("lk_ch_b2",   32'(a_ch),    32'h2);
        check("lk_last_b2", 32'(a_olast), 32'h1);
        tick();
        check("lk_wrap_ch",   32'(a_ch),    32'h0);
        check("lk_wrap_data", 32'(a_odata), 32'hA0);

        // Fixed priority: ch1 beats ch3 until ch1 drops
        b_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        b_last  = 4'hF;
        b_valid = 4'b1010;
        #1;
        check("fp_grant1", 32'(b_in_ready), 32'h2);
        tick(); check("fp_ch_a", 32'(b_ch), 32'h1);
        tick(); check("fp_ch_b", 32'(b_ch), 32'h1);
        check("fp_data_b", 32'(b_odata), 32'hB1);
        b_valid = 4'b1000;
        #1;
        check("fp_grant3", 32'(b_in_ready), 32'h8);
        tick(); check("fp_ch_c", 32'(b_ch), 32'h3);

        // Three-channel round robin with exact wrap
        c_data  = {8'hD2, 8'hD1, 8'hD0};
        c_last  = 3'b111;
        c_valid = 3'b111;
        tick(); check("n3_ch0", 32'(c_ch), 32'h0);
        tick(); check("n3_ch1", 32'(c_ch), 32'h1);
        tick(); check("n3_ch2", 32'(c_ch), 32'h2);
        check("n3_data2", 32'(c_odata), 32'hD2);
        tick(); check("n3_ch3", 32'(c_ch), 32'h0);
        check("n3_data3", 32'(c_odata), 32'hD0);

        // Asynchronous reset mid-cycle while A holds a beat
        check("ar_pre_valid", 32'(a_ovalid), 32'h1);
        rst = 1'b1;
        #1;
        check("ar_valid",    32'(a_ovalid),   32'h0);
        check("ar_data",     32'(a_odata),    32'h0);
        check("ar_in_ready", 32'(a_in_ready), 32'h0);
        check("ar_channel",  32'(a_ch),       32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_ptr_cleared", 32'(a_ch),    32'h0);
        check("ar_data_after",  32'(a_odata), 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
